// File: rtl/reg_8.sv
`default_nettype none
// ============================================================================
// Module      : reg_8
// Description : General-purpose storage register with load enable for the EMU
//               datapath (accumulator, operand and address latches). Captures
//               I on a rising clock edge when E is high and holds otherwise.
//               Optional even-parity output P = ^Q when the macro
//               REG8_PARITY_EN is defined; without it, port P is absent.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_8 #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] I,
  input  logic             E,
`ifdef REG8_PARITY_EN
  output logic [WIDTH-1:0] Q,
  output logic             P
`else
  output logic [WIDTH-1:0] Q
`endif
);

  logic [WIDTH-1:0] r_q;

  // Storage element: reset has priority over load; with E low the value holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else if (E) begin
      r_q <= I;
    end
  end

  // Q is driven straight from the flops, so no input reaches it combinationally.
  assign Q = r_q;

`ifdef REG8_PARITY_EN
  // Parity is taken from the registered value, so it changes together with Q.
  assign P = ^r_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_8
// Description : Self-checking bench for reg_8. A vector table drives the main
//               load/hold/reset behaviour; hand-written sequences cover
//               between-edge isolation and sampled-only-at-edge controls.
//               Expected values pass through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_8;

  logic       clock;
  logic       reset;
  logic [7:0] I;
  logic       E;
  logic [7:0] Q;
`ifdef REG8_PARITY_EN
  logic       P;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic [7:0] exp_q;
    logic       exp_p;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       p;
  } sb_t;

  sb_t sb_q[$];

  reg_8 #(
    .WIDTH      (8),
    .RESET_VALUE(8'h00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .I    (I),
    .E    (E),
`ifdef REG8_PARITY_EN
    .Q    (Q),
    .P    (P)
`else
    .Q    (Q)
`endif
  );

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input string name, input logic [7:0] q, input logic p);
    sb_t e;
    e.name = name;
    e.q    = q;
    e.p    = p;
    sb_q.push_back(e);
  endtask

  // Compare the DUT output against the oldest scoreboard entry.
  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_q"}, Q, e.q);
`ifdef REG8_PARITY_EN
      check({e.name, "_p"}, {7'd0, P}, {7'd0, e.p});
`endif
    end
  endtask

  // Drive one vector in the low phase, then check #1 after the rising edge.
  task automatic apply(input string name, input logic rst, input logic en,
                       input logic [7:0] din, input logic [7:0] exp_q, input logic exp_p);
    @(negedge clock);
    reset = rst;
    E     = en;
    I     = din;
    push_exp(name, exp_q, exp_p);
    @(posedge clock);
    #1;
    pop_check();
  endtask

  vec_t       vecs[11];
  logic [7:0] model_q;
  logic [7:0] rnd_d;
  logic       rnd_e;
  logic       rnd_r;

  initial begin
    reset = 1'b0;
    E     = 1'b0;
    I     = 8'h00;

    //            rst   en    din    exp_q  exp_p
    vecs[0]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0}; // reset ignores I/E
    vecs[1]  = '{1'b0, 1'b0, 8'h01, 8'h00, 1'b0}; // hold
    vecs[2]  = '{1'b0, 1'b1, 8'h01, 8'h01, 1'b1}; // load
    vecs[3]  = '{1'b0, 1'b1, 8'h0A, 8'h0A, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h0B, 8'h0B, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h77, 8'h0B, 1'b1}; // previous persists
    vecs[6]  = '{1'b1, 1'b1, 8'h55, 8'h00, 1'b0}; // reset beats load
    vecs[7]  = '{1'b0, 1'b1, 8'h55, 8'h55, 1'b0}; // no recovery cycles
    vecs[8]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0}; // all ones
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0}; // all zeros
    vecs[10] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0};

    for (int k = 0; k < 11; k++) begin
      apply($sformatf("vec%0d", k), vecs[k].rst, vecs[k].en, vecs[k].din,
            vecs[k].exp_q, vecs[k].exp_p);
    end

    // E rising while clock is low must not load until the edge.
    apply("hold_setup", 1'b0, 1'b0, 8'h01, 8'h00, 1'b0);
    @(negedge clock);
    #1 E = 1'b1;
    #1 check("e_low_phase", Q, 8'h00);
    push_exp("e_edge", 8'h01, 1'b1);
    @(posedge clock);
    #1 pop_check();

    // I toggling while clock is high is ignored; the next edge takes I at that edge.
    apply("iso_load", 1'b0, 1'b1, 8'hAA, 8'hAA, 1'b0);
    I = 8'h55;
    #1 check("iso_high_55", Q, 8'hAA);
    I = 8'hAA;
    #1 check("iso_high_aa", Q, 8'hAA);
    I = 8'h55;
    #1 check("iso_high_55b", Q, 8'hAA);
    push_exp("iso_edge", 8'h55, 1'b0);
    @(posedge clock);
    #1 pop_check();

    // E and reset pulses between edges are ignored: only edge values matter.
    @(negedge clock);
    E = 1'b0;
    I = 8'h33;
    #1 E = 1'b1;
    #1 reset = 1'b1;
    #1 begin
      E     = 1'b0;
      reset = 1'b0;
    end
    push_exp("glitch_hold", 8'h55, 1'b0);
    @(posedge clock);
    #1 pop_check();

    // Random traffic against a behavioural model of the register.
    model_q = 8'h55;
    for (int k = 0; k < 40; k++) begin
      rnd_d = 8'($urandom);
      rnd_e = 1'($urandom_range(0, 1));
      rnd_r = ($urandom_range(0, 9) == 0);
      if (rnd_r)      model_q = 8'h00;
      else if (rnd_e) model_q = rnd_d;
      apply($sformatf("rnd%0d", k), rnd_r, rnd_e, rnd_d, model_q, ^model_q);
    end

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
